// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display blocks.
// Cathode patterns are active low with bit 7 = dp, bits 6:0 = g..a.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned DIG_W      = NUM_DIGITS * NIB_W;
    localparam int unsigned SEG_W      = 8;

    localparam logic [SEG_W-1:0] SEG_0 = 8'hC0;
    localparam logic [SEG_W-1:0] SEG_1 = 8'hF9;
    localparam logic [SEG_W-1:0] SEG_2 = 8'hA4;
    localparam logic [SEG_W-1:0] SEG_3 = 8'hB0;
    localparam logic [SEG_W-1:0] SEG_4 = 8'h99;
    localparam logic [SEG_W-1:0] SEG_5 = 8'h92;
    localparam logic [SEG_W-1:0] SEG_6 = 8'h82;
    localparam logic [SEG_W-1:0] SEG_7 = 8'hF8;
    localparam logic [SEG_W-1:0] SEG_8 = 8'h80;
    localparam logic [SEG_W-1:0] SEG_9 = 8'h90;
    localparam logic [SEG_W-1:0] SEG_A = 8'h88;
    localparam logic [SEG_W-1:0] SEG_B = 8'h83;
    localparam logic [SEG_W-1:0] SEG_C = 8'hA7;
    localparam logic [SEG_W-1:0] SEG_D = 8'hA1;
    localparam logic [SEG_W-1:0] SEG_E = 8'h86;
    localparam logic [SEG_W-1:0] SEG_F = 8'h8E;

    localparam logic [SEG_W-1:0]      SEG_OFF = 8'hFF;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'hF;

    typedef logic [1:0] scan_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } hs_state_e;

    // Display image as held in the pending and active buffers.
    typedef struct packed {
        logic [DIG_W-1:0]      digits;
        logic [NUM_DIGITS-1:0] blank;
        logic [NUM_DIGITS-1:0] dp;
    } image_t;

    localparam image_t IMG_RESET = '{digits: '0, blank: 4'hF, dp: '0};

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble + decimal point to active-low cathode pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    input  logic             dp,
    output logic [SEG_W-1:0] seg_c
);

    logic [6:0] pat;

    always_comb begin
        pat = SEG_OFF[6:0];
        case (nib)
            4'h0: pat = SEG_0[6:0];
            4'h1: pat = SEG_1[6:0];
            4'h2: pat = SEG_2[6:0];
            4'h3: pat = SEG_3[6:0];
            4'h4: pat = SEG_4[6:0];
            4'h5: pat = SEG_5[6:0];
            4'h6: pat = SEG_6[6:0];
            4'h7: pat = SEG_7[6:0];
            4'h8: pat = SEG_8[6:0];
            4'h9: pat = SEG_9[6:0];
            4'hA: pat = SEG_A[6:0];
            4'hB: pat = SEG_B[6:0];
            4'hC: pat = SEG_C[6:0];
            4'hD: pat = SEG_D[6:0];
            4'hE: pat = SEG_E[6:0];
            4'hF: pat = SEG_F[6:0];
            default: pat = SEG_OFF[6:0];
        endcase
        seg_c = {~dp, pat};
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit seven-segment scan controller with dead time and frame-aligned
// double-buffered updates. Define SEG7_BLINK_EN to add per-digit blinking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned DEAD_CYC  = 2,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DIG_W-1:0]      digits_in,
    input  logic [NUM_DIGITS-1:0] blank_in,
    input  logic [NUM_DIGITS-1:0] dp_in,
`ifdef SEG7_BLINK_EN
    input  logic [NUM_DIGITS-1:0] blink_in,
`endif
    output logic [NUM_DIGITS-1:0] an,
    output logic [SEG_W-1:0]      seg,
    output logic                  update_done
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // Reject configurations where the dead time would swallow the whole slot.
    if ((SCAN_DIV < DEAD_CYC + 2) || (BLINK_DIV == 0)) begin : g_param_check
        $error("seg7_scan_ctrl: need SCAN_DIV >= DEAD_CYC+2 and BLINK_DIV > 0");
    end

    logic [CNT_W-1:0]      cnt;
    scan_idx_t             slot;
    logic                  term_c;
    logic                  frame_end_c;

    hs_state_e             state;
    hs_state_e             state_next;
    logic                  accept_c;
    logic                  commit_c;

    image_t                in_img;
    image_t                pend_img;
    image_t                act_img;
    logic [NUM_DIGITS-1:0] eff_blank;

    logic [NIB_W-1:0]      nib_c;
    logic                  dp_c;
    logic                  dark_c;
    logic [SEG_W-1:0]      dec_seg_c;
    logic [NUM_DIGITS-1:0] an_next;
    logic [SEG_W-1:0]      seg_next;

    assign term_c      = (cnt == CNT_W'(SCAN_DIV - 1));
    assign frame_end_c = term_c && (slot == scan_idx_t'(3));

    // Slot prescaler and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            slot <= '0;
        end else if (term_c) begin
            cnt  <= '0;
            slot <= slot + scan_idx_t'(1);
        end else begin
            cnt  <= cnt + CNT_W'(1);
        end
    end

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Accept in IDLE; commit the pending image only on the last cycle of a frame.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        commit_c   = 1'b0;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    accept_c   = 1'b1;
                    state_next = PEND;
                end
            end
            PEND: begin
                if (frame_end_c) begin
                    commit_c   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_ready  <= 1'b1;
            update_done <= 1'b0;
        end else begin
            load_ready  <= (state_next == IDLE);
            update_done <= commit_c;
        end
    end

    always_comb begin
        in_img        = IMG_RESET;
        in_img.digits = digits_in;
        in_img.blank  = blank_in;
        in_img.dp     = dp_in;
    end

    // Pending and active image buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_img <= IMG_RESET;
            act_img  <= IMG_RESET;
        end else begin
            if (accept_c) begin
                pend_img <= in_img;
            end
            if (commit_c) begin
                act_img <= pend_img;
            end
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLK_W-1:0]      blink_cnt;
    logic                  blink_phase;
    logic [NUM_DIGITS-1:0] pend_blink;
    logic [NUM_DIGITS-1:0] act_blink;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BLK_W'(1);
        end
    end

    // Blink mask travels through the same double buffer as the image.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_blink <= '0;
            act_blink  <= '0;
        end else begin
            if (accept_c) begin
                pend_blink <= blink_in;
            end
            if (commit_c) begin
                act_blink <= pend_blink;
            end
        end
    end

    assign eff_blank = act_img.blank | (blink_phase ? act_blink : '0);
`else
    assign eff_blank = act_img.blank;
`endif

    always_comb begin
        nib_c  = act_img.digits[{slot, 2'b00} +: NIB_W];
        dp_c   = act_img.dp[slot];
        dark_c = (cnt < CNT_W'(DEAD_CYC)) || eff_blank[slot];
    end

    seg7_hex_decode u_hex_decode (
        .nib   (nib_c),
        .dp    (dp_c),
        .seg_c (dec_seg_c)
    );

    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_OFF;
        if (!dark_c) begin
            an_next  = ~(NUM_DIGITS'(1) << slot);
            seg_next = dec_seg_c;
        end
    end

    // Pin drivers: one cycle behind the prescaler/index that selects them.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexing scheduler that shares the single 4-anode / 8-cathode seven-segment bus between four hex digits. It owns the refresh prescaler, the digit scan sequence and anti-ghosting dead time. Display updates arrive through a valid/ready handshake and are double-buffered, so they commit only at frame boundaries and never tear. Sits between the board top level (switch/button logic) and the an/seg pins.

Parameters:
SCAN_DIV, 100000, clk cycles per digit slot (1 kHz slot, 250 Hz frame at 100 MHz); must be >= DEAD_CYC+2
DEAD_CYC, 2, cycles at the start of each slot with all anodes off
BLINK_DIV, 25000000, clk cycles per blink phase toggle (BLINK_EN only)

Ports:
clk  in  1  100 MHz system clock
rst  in  1  synchronous active-high reset
load_valid  in  1  new display image offered
load_ready  out  1  controller can accept an image (no commit pending)
digits_in  in  16  four hex nibbles; [3:0] = rightmost digit 0
blank_in  in  4  per-digit blank, 1 = digit dark
dp_in  in  4  per-digit decimal point, 1 = lit
blink_in  in  4  per-digit blink enable (present only with BLINK_EN)
an  out  4  anodes, active low, registered
seg  out  8  cathodes, active low, registered; seg[7] = dp, seg[6:0] = g..a
update_done  out  1  one-cycle pulse when a pending image commits

Behaviour:
- Reset (sync, takes effect on the clk edge with rst=1): an=4'b1111, seg=8'hFF, load_ready=1, update_done=0, prescaler=0, slot index=0, blink phase=0. Active image: digits=0, blank=4'b1111, dp=0. Pending buffer cleared.
- Prescaler counts 0..SCAN_DIV-1. At the terminal count it wraps to 0 and the slot index advances 0->1->2->3->0.
- Slot i, prescaler < DEAD_CYC: an=1111, seg=FF (dead time).
- Slot i, otherwise: an = ~(1<<i), seg = {~dp[i], decode(digit[i])}.
- If digit i is blanked, the whole slot drives an=1111, seg=FF.
- an/seg are registered: values appear 1 cycle after the prescaler/index state that selects them.
- Decode patterns (seg[6:0], active low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=27, d=21, E=06, F=0E. With dp off, seg[7]=1, giving full bytes C0, F9, A4, B0, 99, 92, 82, F8, 80, 90, 88, 83, A7, A1, 86, 8E.
- Handshake: a transfer occurs when load_valid & load_ready. The image (digits, blank, dp, blink) is captured into the pending buffer; load_ready drops the next cycle.
- load_valid with load_ready=0 is stalled. The source holds its data; nothing is dropped.
- Commit: on the cycle where pending=1, slot=3 and prescaler=SCAN_DIV-1:
  - active image <= pending buffer;
  - update_done=1 for exactly one cycle (the following cycle);
  - load_ready returns to 1 that same following cycle.
  The first slot of the new frame shows the new image.
- A transfer that lands on the frame-boundary cycle while pending=0 is not bypassed. It commits at the next frame boundary.
- Reset mid-operation: the pending image is discarded, no update_done is issued, and the display goes dark per the reset values.
- State machine: IDLE (pending=0, ready=1) -> PEND on transfer; PEND -> IDLE on commit.

Optional Feature:
SEG7_BLINK_EN
- Defined:
  - blink_in port exists and is captured with the image.
  - A counter toggles blink_phase every BLINK_DIV cycles.
  - When blink_phase=1, any digit with blink bit set is treated as blanked.
  - The counter resets to 0 with phase 0 (visible).
- Undefined: no blink_in port, no blink counter or register; blink behaves as 0.

Decomposition:
- Package seg7_pkg:
  - SEG_0..SEG_F active-low 8-bit patterns;
  - SEG_OFF=8'hFF, AN_OFF=4'hF;
  - scan index typedef (2-bit);
  - handshake state enum {IDLE, PEND}.
- Sub-module seg7_hex_decode: combinational nibble + dp -> 8-bit cathode pattern. It is reused by other display blocks.

Test Plan (SCAN_DIV=8, DEAD_CYC=1, BLINK_DIV=64):
1. rst held 3 cycles -> an=1111, seg=FF, load_ready=1, update_done=0; display stays dark across 2 full frames.
2. Load digits=16'h12AF, blank=0, dp=4'b0001 -> one update_done pulse at the frame boundary. Next frame, each slot's first cycle is an=1111, then:
   - slot0: an=1110, seg=0E
   - slot1: an=1101, seg=88
   - slot2: an=1011, seg=A4
   - slot3: an=0111, seg=F9
3. Two back-to-back loads (16'h1111 then 16'h2222), valid held -> load_ready low from accept until commit. Second image accepted the cycle after the first update_done and shown one frame later; two update_done pulses in total.
4. blank=4'b0100, digits=16'h8888 -> slot2 shows an=1111, seg=FF for all 8 cycles; other slots show seg=80.
5. Load accepted, then rst asserted in slot 1 before commit -> no update_done; an=1111, seg=FF; load_ready=1 after reset.
6. (SEG7_BLINK_EN) blink=4'b0001, digits=16'h0005 -> slot0 seg alternates between 92 and dark (an=1111) every 64 cycles; slots 1-3 show C0 continuously.
